branch_resolve: RTL and testbench
=================================

BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have port CLK, input, 1, the single rising-edge clock.
REQ-002 SHALL have port RESET, input, 1, synchronous active-high reset.
REQ-003 SHALL have port OP, input, 7, opcode of the current instruction.
REQ-004 SHALL have port funct3, input, 3, branch condition select.
REQ-005 SHALL have ports rs1_val and rs2_val, input, 32 each, register operands.
REQ-006 SHALL have port imm, input, 32, sign-extended immediate.
REQ-007 SHALL have port IP, input, 32, address of the current instruction.
REQ-008 SHALL have port b_taken, output, 1, redirect request to the PC.
REQ-009 SHALL have port up_amt, output, 32, signed byte offset added to IP on redirect.
REQ-010 SHALL have port link_addr, output, 32, IP+4 of the resolved jump for rd writeback.
REQ-011 SHALL have ports resolve_valid and misalign, output, 1 each: result valid, target not 4-byte aligned.

Function
REQ-012 SHALL implement FSM states IDLE and RESOLVE.
REQ-013 SHALL go IDLE->RESOLVE when OP is 1101111 (JAL), 1100111 (JALR) or 1100011 (BRANCH); otherwise it SHALL stay in IDLE.
REQ-014 SHALL go RESOLVE->IDLE unconditionally; OP in the RESOLVE cycle SHALL be ignored.
REQ-015 SHALL register all results on the IDLE->RESOLVE edge, so outputs are valid exactly one cycle after the control-flow OP is presented (latency 1).
REQ-016 SHALL drive resolve_valid=1 only in RESOLVE.
REQ-017 SHALL drive b_taken=0, up_amt=0, link_addr=0 and misalign=0 in IDLE.
REQ-018 BRANCH funct3 SHALL select: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge.
REQ-019 BRANCH funct3 010 and 011 SHALL give not-taken, up_amt=0.
REQ-020 A taken BRANCH SHALL give up_amt=imm; a not-taken BRANCH SHALL give up_amt=0.
REQ-021 JAL SHALL always be taken, with up_amt=imm.
REQ-022 JALR SHALL always be taken, with up_amt=((rs1_val+imm) & ~32'd1) - IP, computed modulo 2^32.
REQ-023 link_addr SHALL be IP+4 for JAL/JALR and 0 for BRANCH; IP+4 SHALL wrap modulo 2^32.
REQ-024 If a taken result has (IP+up_amt)[1:0] != 0, misalign SHALL be 1, b_taken SHALL be 0 and up_amt SHALL be 0.

Reset
REQ-025 RESET high at a clock edge SHALL force state IDLE and all outputs to 0 on the next cycle, including when RESET arrives in RESOLVE.
REQ-026 A control-flow OP presented while RESET is high SHALL NOT be captured.

Configuration
REQ-027 With BRANCH_RESOLVE_STATS_EN defined, the module SHALL add 16-bit outputs resolve_cnt and taken_cnt.
REQ-028 resolve_cnt SHALL increment on each IDLE->RESOLVE transition; taken_cnt SHALL increment on each transition whose registered b_taken is 1.
REQ-029 Both counters SHALL saturate at 16'hFFFF and SHALL clear on RESET.
REQ-030 Without BRANCH_RESOLVE_STATS_EN, the counter ports and logic SHALL be absent and the behaviour otherwise identical.

Structure
REQ-031 Shared package riscv_pkg SHALL hold the opcode constants (JAL, JALR, BRANCH), the funct3 branch-condition encodings and the IDLE/RESOLVE state enum.
REQ-032 The comparator SHALL be a sub-module branch_cmp (inputs a, b, funct3; output take), purely combinational.

Verification
REQ-033 OP=1100011, funct3=000, rs1=rs2=5, imm=16, IP=0x100 -> next cycle resolve_valid=1, b_taken=1, up_amt=16, link_addr=0; following cycle all outputs 0.
REQ-034 funct3=100, rs1=0xFFFFFFFF, rs2=1 -> taken (signed); funct3=110 with the same operands -> b_taken=0, up_amt=0.
REQ-035 OP=1100111, rs1=0x203, imm=4, IP=0x100 -> b_taken=1, up_amt=0x106 (target 0x206) ... then misalign=1, b_taken=0, up_amt=0; with rs1=0x201 -> target 0x204, up_amt=0x104, link_addr=0x104.
REQ-036 JAL followed back-to-back by a BRANCH in the RESOLVE cycle -> the BRANCH is ignored, and the FSM returns to IDLE after one RESOLVE cycle.
REQ-037 RESET asserted in RESOLVE -> next cycle all outputs 0 and state IDLE; with BRANCH_RESOLVE_STATS_EN, 70000 taken JALs -> taken_cnt=resolve_cnt=0xFFFF.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared control-flow definitions: opcodes, branch condition encodings and
// the resolver state enum.
package riscv_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    IDLE    = 1'b0,
    RESOLVE = 1'b1
  } state_t;

  function automatic logic is_ctrl_flow(input logic [6:0] op);
    return (op == OP_JAL) || (op == OP_JALR) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluator; reserved encodings are not-taken.
module branch_cmp
  import riscv_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  funct3,
  output logic        take
);

  always_comb begin
    take = 1'b0;
    case (funct3)
      F3_BEQ:  take = (a == b);
      F3_BNE:  take = (a != b);
      F3_BLT:  take = ($signed(a) < $signed(b));
      F3_BGE:  take = ($signed(a) >= $signed(b));
      F3_BLTU: take = (a < b);
      F3_BGEU: take = (a >= b);
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Branch/jump resolver with one-cycle registered result.
// Optional BRANCH_RESOLVE_STATS_EN adds saturating resolve/taken counters.
module branch_resolve
  import riscv_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [6:0]  OP,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [31:0] imm,
  input  logic [31:0] IP,
  output logic        b_taken,
  output logic [31:0] up_amt,
  output logic [31:0] link_addr,
  output logic        resolve_valid,
  output logic        misalign
`ifdef BRANCH_RESOLVE_STATS_EN
  ,
  output logic [15:0] resolve_cnt,
  output logic [15:0] taken_cnt
`endif
);

  state_t      state_reg, state_next;
  logic        b_taken_reg, b_taken_next;
  logic [31:0] up_amt_reg, up_amt_next;
  logic [31:0] link_reg, link_next;
  logic        mis_reg, mis_next;

  logic        cmp_take;
  logic        res_taken;
  logic [31:0] res_amt;
  logic [31:0] res_link;
  logic [31:0] res_target;
  logic [31:0] jalr_target;

  branch_cmp u_cmp (
    .a      (rs1_val),
    .b      (rs2_val),
    .funct3 (funct3),
    .take   (cmp_take)
  );

  assign jalr_target = (rs1_val + imm) & ~32'd1;

  always_comb begin
    res_taken = 1'b0;
    res_amt   = 32'd0;
    res_link  = 32'd0;
    case (OP)
      OP_JAL: begin
        res_taken = 1'b1;
        res_amt   = imm;
        res_link  = IP + 32'd4;
      end
      OP_JALR: begin
        res_taken = 1'b1;
        res_amt   = jalr_target - IP;
        res_link  = IP + 32'd4;
      end
      OP_BRANCH: begin
        res_taken = cmp_take;
        res_amt   = cmp_take ? imm : 32'd0;
      end
      default: ;
    endcase
  end

  assign res_target = IP + res_amt;

  always_comb begin
    state_next   = state_reg;
    b_taken_next = 1'b0;
    up_amt_next  = 32'd0;
    link_next    = 32'd0;
    mis_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (is_ctrl_flow(OP)) begin
          state_next = RESOLVE;
          link_next  = res_link;
          // A misaligned target suppresses the redirect but keeps the link value
          if (res_taken && (res_target[1:0] != 2'b00)) begin
            mis_next = 1'b1;
          end else begin
            b_taken_next = res_taken;
            up_amt_next  = res_amt;
          end
        end
      end
      RESOLVE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg   <= IDLE;
      b_taken_reg <= 1'b0;
      up_amt_reg  <= 32'd0;
      link_reg    <= 32'd0;
      mis_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      b_taken_reg <= b_taken_next;
      up_amt_reg  <= up_amt_next;
      link_reg    <= link_next;
      mis_reg     <= mis_next;
    end
  end

  assign b_taken       = b_taken_reg;
  assign up_amt        = up_amt_reg;
  assign link_addr     = link_reg;
  assign misalign      = mis_reg;
  assign resolve_valid = (state_reg == RESOLVE);

`ifdef BRANCH_RESOLVE_STATS_EN
  logic [15:0] resolve_cnt_reg;
  logic [15:0] taken_cnt_reg;
  logic        capture;

  assign capture = (state_reg == IDLE) && (state_next == RESOLVE);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      resolve_cnt_reg <= 16'd0;
      taken_cnt_reg   <= 16'd0;
    end else if (capture) begin
      if (resolve_cnt_reg != 16'hFFFF) resolve_cnt_reg <= resolve_cnt_reg + 16'd1;
      if (b_taken_next && (taken_cnt_reg != 16'hFFFF)) taken_cnt_reg <= taken_cnt_reg + 16'd1;
    end
  end

  assign resolve_cnt = resolve_cnt_reg;
  assign taken_cnt   = taken_cnt_reg;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed table-driven bench for branch_resolve plus hand-written corner sequences.
module tb_branch_resolve;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [6:0]  OP;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val, imm, IP;
  logic        b_taken;
  logic [31:0] up_amt;
  logic [31:0] link_addr;
  logic        resolve_valid;
  logic        misalign;
`ifdef BRANCH_RESOLVE_STATS_EN
  logic [15:0] resolve_cnt;
  logic [15:0] taken_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  branch_resolve dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .OP            (OP),
    .funct3        (funct3),
    .rs1_val       (rs1_val),
    .rs2_val       (rs2_val),
    .imm           (imm),
    .IP            (IP),
    .b_taken       (b_taken),
    .up_amt        (up_amt),
    .link_addr     (link_addr),
    .resolve_valid (resolve_valid),
    .misalign      (misalign)
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    .resolve_cnt   (resolve_cnt),
    .taken_cnt     (taken_cnt)
`endif
  );

  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] NOP = 7'b0010011;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] ip;
    logic        e_taken;
    logic [31:0] e_amt;
    logic [31:0] e_link;
    logic        e_mis;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " valid"}, {31'd0, resolve_valid}, 32'd0);
    check({tag, " taken"}, {31'd0, b_taken}, 32'd0);
    check({tag, " amt"}, up_amt, 32'd0);
    check({tag, " link"}, link_addr, 32'd0);
    check({tag, " mis"}, {31'd0, misalign}, 32'd0);
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] im, input logic [31:0] ip);
    OP = op; funct3 = f3; rs1_val = r1; rs2_val = r2; imm = im; IP = ip;
  endtask

  initial begin
    vecs[0]  = '{BR,   3'b000, 32'd5,        32'd5, 32'd16,       32'h100,      1'b1, 32'd16,       32'd0,      1'b0};
    vecs[1]  = '{BR,   3'b100, 32'hFFFFFFFF, 32'd1, 32'd8,        32'h100,      1'b1, 32'd8,        32'd0,      1'b0};
    vecs[2]  = '{BR,   3'b110, 32'hFFFFFFFF, 32'd1, 32'd8,        32'h100,      1'b0, 32'd0,        32'd0,      1'b0};
    vecs[3]  = '{BR,   3'b001, 32'd5,        32'd5, 32'd16,       32'h100,      1'b0, 32'd0,        32'd0,      1'b0};
    vecs[4]  = '{BR,   3'b101, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFF8, 32'h100,      1'b1, 32'hFFFFFFF8, 32'd0,      1'b0};
    vecs[5]  = '{BR,   3'b111, 32'hFFFFFFFF, 32'd1, 32'd12,       32'h100,      1'b1, 32'd12,       32'd0,      1'b0};
    vecs[6]  = '{BR,   3'b010, 32'd7,        32'd7, 32'd16,       32'h100,      1'b0, 32'd0,        32'd0,      1'b0};
    vecs[7]  = '{BR,   3'b011, 32'd0,        32'd9, 32'd16,       32'h100,      1'b0, 32'd0,        32'd0,      1'b0};
    vecs[8]  = '{JALR, 3'b000, 32'h203,      32'd0, 32'd4,        32'h100,      1'b0, 32'd0,        32'h104,    1'b1};
    vecs[9]  = '{JALR, 3'b000, 32'h201,      32'd0, 32'd4,        32'h100,      1'b1, 32'h104,      32'h104,    1'b0};
    vecs[10] = '{JAL,  3'b000, 32'd0,        32'd0, 32'h20,       32'h1000,     1'b1, 32'h20,       32'h1004,   1'b0};
    vecs[11] = '{JAL,  3'b000, 32'd0,        32'd0, 32'd8,        32'hFFFFFFFC, 1'b1, 32'd8,        32'd0,      1'b0};
    vecs[12] = '{BR,   3'b000, 32'd3,        32'd3, 32'd6,        32'h100,      1'b0, 32'd0,        32'd0,      1'b1};
    vecs[13] = '{JAL,  3'b000, 32'd0,        32'd0, 32'd2,        32'h200,      1'b0, 32'd0,        32'h204,    1'b1};
    vecs[14] = '{BR,   3'b001, 32'd3,        32'd3, 32'd6,        32'h100,      1'b0, 32'd0,        32'd0,      1'b0};
    vecs[15] = '{JALR, 3'b000, 32'h80,       32'd0, 32'hFFFFFFFC, 32'h200,      1'b1, 32'hFFFFFE7C, 32'h204,    1'b0};

    RESET = 1'b1;
    drive(NOP, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0);
    repeat (3) @(posedge CLK);
    #1;
    check_idle("reset");
`ifdef BRANCH_RESOLVE_STATS_EN
    check("reset rcnt", {16'd0, resolve_cnt}, 32'd0);
    check("reset tcnt", {16'd0, taken_cnt}, 32'd0);
`endif
    @(negedge CLK);
    RESET = 1'b0;

    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      drive(vecs[i].op, vecs[i].f3, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].ip);
      @(posedge CLK);
      #1;
      check($sformatf("v%0d valid", i), {31'd0, resolve_valid}, 32'd1);
      check($sformatf("v%0d taken", i), {31'd0, b_taken}, {31'd0, vecs[i].e_taken});
      check($sformatf("v%0d amt", i), up_amt, vecs[i].e_amt);
      check($sformatf("v%0d link", i), link_addr, vecs[i].e_link);
      check($sformatf("v%0d mis", i), {31'd0, misalign}, {31'd0, vecs[i].e_mis});
      $display("vec %0d op=%b f3=%b rs1=%h rs2=%h imm=%h ip=%h -> taken=%b amt=%h link=%h mis=%b",
               i, vecs[i].op, vecs[i].f3, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].ip,
               b_taken, up_amt, link_addr, misalign);
      @(negedge CLK);
      drive(NOP, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0);
      @(posedge CLK);
      #1;
      check_idle($sformatf("v%0d after", i));
    end

    // JAL immediately followed by a BRANCH held during the RESOLVE cycle
    @(negedge CLK);
    drive(JAL, 3'b000, 32'd0, 32'd0, 32'h40, 32'h300);
    @(posedge CLK);
    #1;
    check("b2b jal valid", {31'd0, resolve_valid}, 32'd1);
    check("b2b jal link", link_addr, 32'h304);
    @(negedge CLK);
    drive(BR, 3'b000, 32'd1, 32'd1, 32'd16, 32'h304);
    @(posedge CLK);
    #1;
    check_idle("b2b ignored");
    @(negedge CLK);
    drive(NOP, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0);
    @(posedge CLK);
    #1;
    check_idle("b2b settle");
    $display("seq back-to-back jal/branch done");

    // Reset arriving in RESOLVE, with a JAL held through reset
    @(negedge CLK);
    drive(JAL, 3'b000, 32'd0, 32'd0, 32'h10, 32'h400);
    @(posedge CLK);
    #1;
    check("rst-in-res valid", {31'd0, resolve_valid}, 32'd1);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    check_idle("rst-in-res");
    @(posedge CLK);
    #1;
    check_idle("rst-hold jal");
    @(negedge CLK);
    RESET = 1'b0;
    drive(NOP, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0);
    @(posedge CLK);
    #1;
    check_idle("rst-release");
    $display("seq reset in RESOLVE done");

`ifdef BRANCH_RESOLVE_STATS_EN
    check("cnt after reset r", {16'd0, resolve_cnt}, 32'd0);
    check("cnt after reset t", {16'd0, taken_cnt}, 32'd0);
    for (int k = 0; k < 70000; k++) begin
      @(negedge CLK);
      drive(JAL, 3'b000, 32'd0, 32'd0, 32'd8, 32'h0);
      @(negedge CLK);
      drive(NOP, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0);
    end
    @(posedge CLK);
    #1;
    check("sat rcnt", {16'd0, resolve_cnt}, 32'h0000FFFF);
    check("sat tcnt", {16'd0, taken_cnt}, 32'h0000FFFF);
    $display("seq counter saturation rcnt=%h tcnt=%h", resolve_cnt, taken_cnt);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
